// File: rtl/cv32e41s_rf_scrubber.sv
// Background ECC scrubber for the secure register file: steals idle read-port cycles,
// checks each word through the external decoder and writes back corrected single-bit errors.
module cv32e41s_rf_scrubber #(
  parameter int NUM_WORDS      = 32,
  parameter int WORD_WIDTH     = 38,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         rd_port_free_i,
  output logic                         scrub_re_o,
  output logic [$clog2(NUM_WORDS)-1:0] scrub_raddr_o,
  input  logic                         dec_err_single_i,
  input  logic                         dec_err_double_i,
  input  logic [WORD_WIDTH-1:0]        dec_data_i,
  input  logic                         core_we_i,
  input  logic [$clog2(NUM_WORDS)-1:0] core_waddr_i,
  output logic                         wb_req_o,
  input  logic                         wb_gnt_i,
  output logic [$clog2(NUM_WORDS)-1:0] wb_addr_o,
  output logic [WORD_WIDTH-1:0]        wb_data_o,
  output logic                         alert_minor_o,
  output logic                         alert_major_o,
  output logic                         sweep_done_o,
  output logic [CNT_WIDTH-1:0]         corr_cnt_o
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int IW = $clog2(SCRUB_INTERVAL);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WRITEBACK = 2'd2
  } state_e;

  state_e                state_q;
  logic [IW-1:0]         cnt_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         wb_addr_q;
  logic [WORD_WIDTH-1:0] wb_data_q;
  logic [CNT_WIDTH-1:0]  corr_cnt_q;
  logic                  alert_minor_q;
  logic                  alert_major_q;
  logic                  sweep_done_q;

  logic                  core_hits_addr;
  logic                  core_hits_wb;
  logic                  accept;
  logic                  wrap;
  logic [AW-1:0]         addr_adv;

  // A core write to the word under inspection makes the read data (or the pending fix) stale.
  assign core_hits_addr = core_we_i && (core_waddr_i == addr_q);
  assign core_hits_wb   = core_we_i && (core_waddr_i == wb_addr_q);
  assign accept         = (state_q == READ) && rd_port_free_i && enable_i;
  assign wrap           = (addr_q == AW'(NUM_WORDS - 1));
  assign addr_adv       = wrap ? AW'(1) : addr_q + AW'(1);

  assign scrub_re_o     = accept;
  assign scrub_raddr_o  = addr_q;
  assign wb_req_o       = (state_q == WRITEBACK) && !core_hits_wb;
  assign wb_addr_o      = wb_addr_q;
  assign wb_data_o      = wb_data_q;
  assign alert_minor_o  = alert_minor_q;
  assign alert_major_o  = alert_major_q;
  assign sweep_done_o   = sweep_done_q;
  assign corr_cnt_o     = corr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= AW'(1);
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      corr_cnt_q    <= '0;
      alert_minor_q <= 1'b0;
      alert_major_q <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      alert_minor_q <= 1'b0;
      alert_major_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!enable_i) begin
            cnt_q <= '0;
          end else if (cnt_q == IW'(SCRUB_INTERVAL - 1)) begin
            cnt_q   <= '0;
            state_q <= READ;
          end else begin
            cnt_q <= cnt_q + IW'(1);
          end
        end
        READ: begin
          if (!enable_i) begin
            state_q <= IDLE;
          end else if (rd_port_free_i) begin
            if (!core_hits_addr && !dec_err_double_i && dec_err_single_i) begin
              wb_addr_q <= addr_q;
              wb_data_q <= dec_data_i;
              state_q   <= WRITEBACK;
            end else begin
              alert_major_q <= dec_err_double_i && !core_hits_addr;
              addr_q        <= addr_adv;
              sweep_done_q  <= wrap;
              state_q       <= IDLE;
            end
          end
        end
        WRITEBACK: begin
          // Completes on grant or on a colliding core write; enable_i is deliberately ignored here.
          if (core_hits_wb || wb_gnt_i) begin
            addr_q       <= addr_adv;
            sweep_done_q <= wrap;
            state_q      <= IDLE;
            if (!core_hits_wb) begin
              alert_minor_q <= 1'b1;
              if (corr_cnt_q != '1) begin
                corr_cnt_q <= corr_cnt_q + CNT_WIDTH'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e41s_rf_scrubber.sv
// Self-checking bench for cv32e41s_rf_scrubber: directed scenarios plus a randomized run
// compared against a cycle-count based reference model.
module tb_cv32e41s_rf_scrubber;

  localparam int NW  = 32;
  localparam int WW  = 38;
  localparam int SI  = 4;
  localparam int CW  = 8;
  localparam int AW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i;
  logic          rd_port_free_i;
  logic          scrub_re_o;
  logic [AW-1:0] scrub_raddr_o;
  logic          dec_err_single_i;
  logic          dec_err_double_i;
  logic [WW-1:0] dec_data_i;
  logic          core_we_i;
  logic [AW-1:0] core_waddr_i;
  logic          wb_req_o;
  logic          wb_gnt_i;
  logic [AW-1:0] wb_addr_o;
  logic [WW-1:0] wb_data_o;
  logic          alert_minor_o;
  logic          alert_major_o;
  logic          sweep_done_o;
  logic [CW-1:0] corr_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cv32e41s_rf_scrubber #(
    .NUM_WORDS     (NW),
    .WORD_WIDTH    (WW),
    .SCRUB_INTERVAL(SI),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .rd_port_free_i  (rd_port_free_i),
    .scrub_re_o      (scrub_re_o),
    .scrub_raddr_o   (scrub_raddr_o),
    .dec_err_single_i(dec_err_single_i),
    .dec_err_double_i(dec_err_double_i),
    .dec_data_i      (dec_data_i),
    .core_we_i       (core_we_i),
    .core_waddr_i    (core_waddr_i),
    .wb_req_o        (wb_req_o),
    .wb_gnt_i        (wb_gnt_i),
    .wb_addr_o       (wb_addr_o),
    .wb_data_o       (wb_data_o),
    .alert_minor_o   (alert_minor_o),
    .alert_major_o   (alert_major_o),
    .sweep_done_o    (sweep_done_o),
    .corr_cnt_o      (corr_cnt_o)
  );

  task automatic clear_inputs();
    enable_i         = 1'b0;
    rd_port_free_i   = 1'b0;
    dec_err_single_i = 1'b0;
    dec_err_double_i = 1'b0;
    dec_data_i       = '0;
    core_we_i        = 1'b0;
    core_waddr_i     = '0;
    wb_gnt_i         = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Steps whole cycles until scrub_re_o is seen (returns inside that cycle), or -1 on timeout.
  task automatic go_to_read(input int max_cyc, output int waited);
    waited = -1;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (scrub_re_o) begin
        waited = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic skip_clean_reads(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      go_to_read(20, w);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int w;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({scrub_re_o, wb_req_o, alert_minor_o, alert_major_o, sweep_done_o} !== 5'b0)
      $display("FAIL reset_flags got=%b want=00000",
               {scrub_re_o, wb_req_o, alert_minor_o, alert_major_o, sweep_done_o});
    else n_pass++;
    n_checks++;
    if (wb_addr_o !== '0 || wb_data_o !== '0) $display("FAIL reset_wb got=%h/%h want=0/0", wb_addr_o, wb_data_o);
    else n_pass++;
    n_checks++;
    if (corr_cnt_o !== '0) $display("FAIL reset_cnt got=%h want=0", corr_cnt_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    go_to_read(10, w);
    n_checks++;
    if (w !== -1) $display("FAIL reset_disabled_read got=%0d want=-1", w);
    else n_pass++;
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    go_to_read(20, w);
    n_checks++;
    if (w !== SI || scrub_raddr_o !== AW'(1))
      $display("FAIL reset_first_read got=%0d@%0d want=%0d@1", w, scrub_raddr_o, SI);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_sweep();
    int w;
    int exp_addr;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    for (int k = 1; k <= NW; k++) begin
      exp_addr = (k == NW) ? 1 : k;
      go_to_read(20, w);
      n_checks++;
      if (w !== SI) $display("FAIL sweep_interval k=%0d got=%0d want=%0d", k, w, SI);
      else n_pass++;
      n_checks++;
      if (scrub_raddr_o !== AW'(exp_addr)) $display("FAIL sweep_addr got=%0d want=%0d", scrub_raddr_o, exp_addr);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if (sweep_done_o !== (k == NW - 1))
        $display("FAIL sweep_done k=%0d got=%b want=%b", k, sweep_done_o, (k == NW - 1));
      else n_pass++;
    end
    $display("test_sweep done");
  endtask

  task automatic test_single_wb();
    int w;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    skip_clean_reads(6);
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(7)) $display("FAIL wb_read_addr got=%0d want=7", scrub_raddr_o);
    else n_pass++;
    dec_err_single_i = 1'b1;
    dec_data_i = 38'h2A_DEADBEEF;
    @(negedge clk);
    dec_err_single_i = 1'b0;
    dec_data_i = '0;
    for (int c = 0; c < 3; c++) begin
      wb_gnt_i = (c == 2);
      #1;
      n_checks++;
      if (wb_req_o !== 1'b1 || wb_addr_o !== AW'(7) || wb_data_o !== 38'h2A_DEADBEEF)
        $display("FAIL wb_hold c=%0d got=%b/%0d/%h want=1/7/2adeadbeef", c, wb_req_o, wb_addr_o, wb_data_o);
      else n_pass++;
      @(negedge clk);
    end
    wb_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (alert_minor_o !== 1'b1 || corr_cnt_o !== CW'(1) || wb_req_o !== 1'b0)
      $display("FAIL wb_done got=%b/%0d/%b want=1/1/0", alert_minor_o, corr_cnt_o, wb_req_o);
    else n_pass++;
    n_checks++;
    if (wb_data_o !== 38'h2A_DEADBEEF) $display("FAIL wb_data_hold got=%h want=2adeadbeef", wb_data_o);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (alert_minor_o !== 1'b0) $display("FAIL wb_minor_width got=%b want=0", alert_minor_o);
    else n_pass++;
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(8)) $display("FAIL wb_next_addr got=%0d want=8", scrub_raddr_o);
    else n_pass++;
    $display("test_single_wb done");
  endtask

  task automatic test_abort();
    int w;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    skip_clean_reads(4);
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(5)) $display("FAIL abort_read_addr got=%0d want=5", scrub_raddr_o);
    else n_pass++;
    dec_err_single_i = 1'b1;
    dec_data_i = 38'h15_12345678;
    @(negedge clk);
    dec_err_single_i = 1'b0;
    #1;
    n_checks++;
    if (wb_req_o !== 1'b1) $display("FAIL abort_req_before got=%b want=1", wb_req_o);
    else n_pass++;
    @(negedge clk);
    core_we_i = 1'b1;
    core_waddr_i = AW'(5);
    wb_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (wb_req_o !== 1'b0) $display("FAIL abort_req_drop got=%b want=0", wb_req_o);
    else n_pass++;
    @(negedge clk);
    core_we_i = 1'b0;
    wb_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (alert_minor_o !== 1'b0 || corr_cnt_o !== '0 || wb_req_o !== 1'b0)
      $display("FAIL abort_after got=%b/%0d/%b want=0/0/0", alert_minor_o, corr_cnt_o, wb_req_o);
    else n_pass++;
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(6)) $display("FAIL abort_next_addr got=%0d want=6", scrub_raddr_o);
    else n_pass++;
    $display("test_abort done");
  endtask

  task automatic test_double();
    int w;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    skip_clean_reads(2);
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(3)) $display("FAIL dbl_read_addr got=%0d want=3", scrub_raddr_o);
    else n_pass++;
    dec_err_single_i = 1'b1;
    dec_err_double_i = 1'b1;
    @(negedge clk);
    dec_err_single_i = 1'b0;
    dec_err_double_i = 1'b0;
    #1;
    n_checks++;
    if ({alert_major_o, alert_minor_o, wb_req_o} !== 3'b100)
      $display("FAIL dbl_alert got=%b want=100", {alert_major_o, alert_minor_o, wb_req_o});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({alert_major_o, alert_minor_o, wb_req_o} !== 3'b000)
      $display("FAIL dbl_pulse_width got=%b want=000", {alert_major_o, alert_minor_o, wb_req_o});
    else n_pass++;
    go_to_read(20, w);
    n_checks++;
    if (scrub_raddr_o !== AW'(4)) $display("FAIL dbl_next_addr got=%0d want=4", scrub_raddr_o);
    else n_pass++;
    $display("test_double done");
  endtask

  task automatic test_port_busy();
    int w;
    int bad;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b0;
    bad = 0;
    for (int c = 0; c < SI + 50; c++) begin
      #1;
      if (scrub_re_o) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL busy_no_read got=%0d reads want=0", bad);
    else n_pass++;
    rd_port_free_i = 1'b1;
    go_to_read(1, w);
    n_checks++;
    if (w !== 0 || scrub_raddr_o !== AW'(1))
      $display("FAIL busy_first_free got=%0d@%0d want=0@1", w, scrub_raddr_o);
    else n_pass++;
    @(negedge clk);
    rd_port_free_i = 1'b0;
    repeat (SI + 2) @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    go_to_read(20, w);
    n_checks++;
    if (w !== SI || scrub_raddr_o !== AW'(2))
      $display("FAIL busy_disable_read got=%0d@%0d want=%0d@2", w, scrub_raddr_o, SI);
    else n_pass++;
    $display("test_port_busy done");
  endtask

  task automatic test_saturate_reset();
    int w;
    int exp_cnt;
    do_reset();
    enable_i = 1'b1;
    rd_port_free_i = 1'b1;
    dec_err_single_i = 1'b1;
    wb_gnt_i = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      go_to_read(20, w);
      dec_data_i = WW'({$urandom, $urandom});
      @(negedge clk);
      @(negedge clk);
      #1;
      exp_cnt = (k > SAT) ? SAT : k;
      n_checks++;
      if (corr_cnt_o !== CW'(exp_cnt)) $display("FAIL sat_cnt k=%0d got=%0d want=%0d", k, corr_cnt_o, exp_cnt);
      else n_pass++;
    end
    wb_gnt_i = 1'b0;
    go_to_read(20, w);
    @(negedge clk);
    #1;
    n_checks++;
    if (wb_req_o !== 1'b1) $display("FAIL sat_in_wb got=%b want=1", wb_req_o);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({scrub_re_o, wb_req_o, alert_minor_o, alert_major_o, sweep_done_o} !== 5'b0 ||
        wb_addr_o !== '0 || wb_data_o !== '0 || corr_cnt_o !== '0)
      $display("FAIL midwb_reset got=%b/%0d/%h/%0d want=00000/0/0/0",
               {scrub_re_o, wb_req_o, alert_minor_o, alert_major_o, sweep_done_o},
               wb_addr_o, wb_data_o, corr_cnt_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dec_err_single_i = 1'b0;
    go_to_read(20, w);
    n_checks++;
    if (w !== SI || scrub_raddr_o !== AW'(1))
      $display("FAIL midwb_restart got=%0d@%0d want=%0d@1", w, scrub_raddr_o, SI);
    else n_pass++;
    $display("test_saturate_reset done");
  endtask

  // Reference: the port is usable once SI consecutive enabled idle cycles have elapsed since the
  // window opened; each finished scrub moves to the next implemented register (1..NW-1).
  task automatic test_random();
    int            m_addr, m_corr, idle_run, target, r;
    bit            in_wb, hit, p_minor, p_major, p_sweep, exp_re, exp_req, adv;
    logic [AW-1:0] wb_addr_exp;
    logic [WW-1:0] wb_data_exp;
    do_reset();
    m_addr = 1;
    m_corr = 0;
    idle_run = 0;
    in_wb = 1'b0;
    p_minor = 1'b0;
    p_major = 1'b0;
    p_sweep = 1'b0;
    wb_addr_exp = '0;
    wb_data_exp = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_checks++;
      if (alert_minor_o !== p_minor) $display("FAIL rnd_minor cyc=%0d got=%b want=%b", cyc, alert_minor_o, p_minor);
      else n_pass++;
      n_checks++;
      if (alert_major_o !== p_major) $display("FAIL rnd_major cyc=%0d got=%b want=%b", cyc, alert_major_o, p_major);
      else n_pass++;
      n_checks++;
      if (sweep_done_o !== p_sweep) $display("FAIL rnd_sweep cyc=%0d got=%b want=%b", cyc, sweep_done_o, p_sweep);
      else n_pass++;
      n_checks++;
      if (corr_cnt_o !== CW'(m_corr)) $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", cyc, corr_cnt_o, m_corr);
      else n_pass++;
      p_minor = 1'b0;
      p_major = 1'b0;
      p_sweep = 1'b0;

      enable_i         = ($urandom_range(0, 9) != 0);
      rd_port_free_i   = ($urandom_range(0, 2) != 0);
      dec_err_single_i = ($urandom_range(0, 2) == 0);
      dec_err_double_i = ($urandom_range(0, 4) == 0);
      dec_data_i       = WW'({$urandom, $urandom});
      wb_gnt_i         = ($urandom_range(0, 2) == 0);
      target = in_wb ? int'(wb_addr_exp) : m_addr;
      hit = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, NW - 1);
      if (r == target) r = (r + 1) % NW;
      core_we_i    = hit ? 1'b1 : ($urandom_range(0, 1) == 1);
      core_waddr_i = AW'(hit ? target : r);
      #1;

      exp_re  = !in_wb && (idle_run == SI) && enable_i && rd_port_free_i;
      exp_req = in_wb && !hit;
      n_checks++;
      if (scrub_re_o !== exp_re) $display("FAIL rnd_re cyc=%0d got=%b want=%b", cyc, scrub_re_o, exp_re);
      else n_pass++;
      n_checks++;
      if (wb_req_o !== exp_req) $display("FAIL rnd_req cyc=%0d got=%b want=%b", cyc, wb_req_o, exp_req);
      else n_pass++;
      n_checks++;
      if (wb_addr_o !== wb_addr_exp || wb_data_o !== wb_data_exp)
        $display("FAIL rnd_wb cyc=%0d got=%0d/%h want=%0d/%h", cyc, wb_addr_o, wb_data_o, wb_addr_exp, wb_data_exp);
      else n_pass++;
      if (exp_re) begin
        n_checks++;
        if (scrub_raddr_o !== AW'(m_addr)) $display("FAIL rnd_raddr cyc=%0d got=%0d want=%0d", cyc, scrub_raddr_o, m_addr);
        else n_pass++;
      end

      adv = 1'b0;
      if (in_wb) begin
        if (hit) begin
          adv = 1'b1;
          in_wb = 1'b0;
        end else if (wb_gnt_i) begin
          adv = 1'b1;
          in_wb = 1'b0;
          p_minor = 1'b1;
          if (m_corr < SAT) m_corr++;
        end
      end else if (idle_run < SI) begin
        idle_run = enable_i ? idle_run + 1 : 0;
      end else if (!enable_i) begin
        idle_run = 0;
      end else if (rd_port_free_i) begin
        idle_run = 0;
        if (hit) adv = 1'b1;
        else if (dec_err_double_i) begin
          adv = 1'b1;
          p_major = 1'b1;
        end else if (dec_err_single_i) begin
          in_wb = 1'b1;
          wb_addr_exp = AW'(m_addr);
          wb_data_exp = dec_data_i;
        end else adv = 1'b1;
      end
      if (adv) begin
        if (m_addr == NW - 1) begin
          m_addr = 1;
          p_sweep = 1'b1;
        end else m_addr++;
      end
      @(negedge clk);
    end
    $display("test_random done, corrections=%0d next_addr=%0d", m_corr, m_addr);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_sweep();
    test_single_wb();
    test_abort();
    test_double();
    test_port_busy();
    test_saturate_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
